// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder: supported opcodes, the
// responder state encoding, the default JEDEC ID and a helper that picks
// one byte of the ID.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;

  localparam logic [23:0] DEFAULT_JEDEC_ID = 24'h20BA18;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    ID,
    STAT,
    IGNORE
  } state_e;

  // ID byte by index, MSB first; indices past the ID read back as zero.
  function automatic logic [7:0] id_byte(logic [23:0] id, logic [1:0] idx);
    case (idx)
      2'd0:    return id[23:16];
      2'd1:    return id[15:8];
      2'd2:    return id[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_responder_sync.sv
// N-stage synchronizer for the SPI pins plus registered rise/fall strobes
// for the serial clock.
//   clk, rst_n            system clock, synchronous active-low reset
//   spi_clk/cs_n/mosi     asynchronous SPI pins
//   sclk_rise/sclk_fall   one-cycle strobes on synchronized spi_clk edges
//   cs_n_q, mosi_q        synchronized pins, aligned with the strobes
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_clk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_n_q,
  output logic mosi_q
);

  logic [STAGES-1:0] sclk_sr;
  logic [STAGES-1:0] cs_sr;
  logic [STAGES-1:0] mosi_sr;
  logic              sclk_d;

  // The chain keeps sampling through reset so that, when reset releases,
  // the synchronized CS already reflects the pin rather than a reset value.
  always_ff @(posedge clk) begin
    sclk_sr[0] <= spi_clk;
    cs_sr[0]   <= spi_cs_n;
    mosi_sr[0] <= spi_mosi;
    for (int i = 1; i < STAGES; i++) begin
      sclk_sr[i] <= sclk_sr[i-1];
      cs_sr[i]   <= cs_sr[i-1];
      mosi_sr[i] <= mosi_sr[i-1];
    end
    sclk_d <= sclk_sr[STAGES-1];
    cs_n_q <= cs_sr[STAGES-1];
    mosi_q <= mosi_sr[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
    end else begin
      sclk_rise <= sclk_sr[STAGES-1] & ~sclk_d;
      sclk_fall <= ~sclk_sr[STAGES-1] & sclk_d;
    end
  end

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder. Decodes READ, RDID and RDSR and streams data
// from a byte-wide synchronous memory port (1-cycle read latency).
//   clk, rst_n        system clock, synchronous active-low reset
//   spi_*             SPI target pins; spi_miso_oe high in response phases
//   mem_rd/mem_addr   one-cycle read strobe and byte address
//   mem_rdata         read data, valid the cycle after mem_rd
//   busy              synchronized chip select active
//   cmd_err           pulse when an unsupported opcode completes
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_W      = 24,
  parameter logic [23:0] JEDEC_ID    = DEFAULT_JEDEC_ID,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  logic rise, fall, cs_n_q, mosi_q;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_clk   (spi_clk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .sclk_rise (rise),
    .sclk_fall (fall),
    .cs_n_q    (cs_n_q),
    .mosi_q    (mosi_q)
  );

  state_e            state;
  logic [2:0]        bit_cnt;
  logic [1:0]        byte_cnt;  // address byte index
  logic [1:0]        id_idx;    // next ID byte to load
  logic [22:0]       in_sr;
  logic [23:0]       in_next;
  logic [7:0]        out_sr;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_pend;   // mem_rdata valid this cycle
  logic              armed;     // CS seen high since reset
  logic              byte_done;
  logic              resp_phase;
  logic              load_en;
  logic [7:0]        load_val;
  logic [7:0]        out_next;

  assign in_next    = {in_sr, mosi_q};
  assign byte_done  = rise && (bit_cnt == 3'd7);
  assign resp_phase = (state == DATA) || (state == ID) || (state == STAT);

  // Byte to present next. A memory load may land in the same cycle as the
  // fall that must drive its MSB, so the fall path uses out_next.
  always_comb begin
    load_en  = 1'b0;
    load_val = 8'h00;
    if (state == DATA && rd_pend) begin
      load_en  = 1'b1;
      load_val = mem_rdata;
    end else if (byte_done && state == CMD) begin
      if (in_next[7:0] == OP_RDID) begin
        load_en  = 1'b1;
        load_val = id_byte(JEDEC_ID, 2'd0);
      end else if (in_next[7:0] == OP_RDSR) begin
        load_en  = 1'b1;
      end
    end else if (byte_done && state == ID) begin
      load_en  = 1'b1;
      load_val = id_byte(JEDEC_ID, id_idx);
    end else if (byte_done && state == STAT) begin
      load_en  = 1'b1;
    end
  end

  assign out_next = load_en ? load_val : out_sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      byte_cnt    <= 2'd0;
      id_idx      <= 2'd0;
      in_sr       <= '0;
      out_sr      <= 8'h00;
      addr_q      <= '0;
      rd_pend     <= 1'b0;
      armed       <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      busy    <= ~cs_n_q;
      cmd_err <= 1'b0;
      mem_rd  <= 1'b0;
      rd_pend <= mem_rd;
      if (cs_n_q) begin
        // CS high ends the frame from any state; partial bytes are dropped.
        state       <= IDLE;
        bit_cnt     <= 3'd0;
        byte_cnt    <= 2'd0;
        id_idx      <= 2'd0;
        out_sr      <= 8'h00;
        rd_pend     <= 1'b0;
        armed       <= 1'b1;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else begin
        case (state)
          // Without armed, a frame interrupted by reset would be decoded
          // from its middle; wait for CS high first.
          IDLE: if (armed) begin
            state    <= CMD;
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
          end
          default: begin
            if (rise) begin
              in_sr   <= in_next[22:0];
              bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
              case (state)
                CMD: begin
                  case (in_next[7:0])
                    OP_READ: begin
                      state    <= ADDR;
                      byte_cnt <= 2'd0;
                    end
                    OP_RDID: begin
                      state  <= ID;
                      id_idx <= 2'd1;
                    end
                    OP_RDSR: state <= STAT;
                    default: begin
                      state   <= IGNORE;
                      cmd_err <= 1'b1;
                    end
                  endcase
                end
                ADDR: begin
                  if (byte_cnt == 2'd2) begin
                    state    <= DATA;
                    addr_q   <= in_next[ADDR_W-1:0];
                    mem_addr <= in_next[ADDR_W-1:0];
                    mem_rd   <= 1'b1;
                  end else begin
                    byte_cnt <= byte_cnt + 2'd1;
                  end
                end
                DATA: begin
                  // Prefetch the next byte while the current one's last bit
                  // is still on the wire.
                  addr_q   <= addr_q + 1'b1;
                  mem_addr <= addr_q + 1'b1;
                  mem_rd   <= 1'b1;
                end
                ID: if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                default: ;
              endcase
            end
            if (fall && resp_phase) begin
              spi_miso    <= out_next[7];
              out_sr      <= {out_next[6:0], 1'b0};
              spi_miso_oe <= 1'b1;
            end else if (load_en) begin
              out_sr <= load_val;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
module tb_spi_flash_responder;

  localparam logic [23:0] JID = 24'h20BA18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe, mem_rd, busy, cmd_err;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;

  always #5 clk = ~clk;

  spi_flash_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_clk     (spi_clk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .cmd_err     (cmd_err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int hp = 6;

  // Memory contents: two fixed bytes, a simple hash elsewhere.
  function automatic logic [7:0] mem_val(logic [23:0] a);
    if (a == 24'h000100) return 8'hA5;
    if (a == 24'h000101) return 8'h3C;
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h69;
  endfunction

  // Memory port model and event monitors.
  int          rd_cnt = 0;
  int          err_cnt = 0;
  int          oe_cyc = 0;
  int          b2b_cnt = 0;
  logic        rd_prev = 1'b0;
  logic [23:0] rd_log [0:4095];

  always @(posedge clk) begin
    rd_prev <= mem_rd;
    if (mem_rd) begin
      mem_rdata           <= mem_val(mem_addr);
      rd_log[rd_cnt[11:0]] <= mem_addr;
      rd_cnt              <= rd_cnt + 1;
    end
    if (mem_rd && rd_prev) b2b_cnt <= b2b_cnt + 1;
    if (cmd_err) err_cnt <= err_cnt + 1;
    if (spi_miso_oe) oe_cyc <= oe_cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One mode-0 bit: data set while SCK low, sampled by us just before rise.
  task automatic spi_bit(input logic b, output logic r, output logic oe);
    spi_mosi = b;
    clks(hp);
    r  = spi_miso;
    oe = spi_miso_oe;
    spi_clk = 1'b1;
    clks(hp);
    spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx,
                          output logic oe_all, output logic oe_any);
    logic r, o;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r, o);
      rx[i]  = r;
      oe_all = oe_all & o;
      oe_any = oe_any | o;
    end
  endtask

  task automatic cs_low();
    hp = $urandom_range(5, 8);
    spi_cs_n = 1'b0;
    clks(hp + 2);
  endtask

  task automatic cs_high();
    clks(hp);
    spi_cs_n = 1'b1;
    clks(hp + 6);
  endtask

  // Send opcode + address and return whether MISO was ever enabled.
  task automatic send_read_hdr(input logic [23:0] a, output logic oe_seen);
    logic [7:0] rx;
    logic oa, on;
    oe_seen = 1'b0;
    spi_byte(8'h03, rx, oa, on); oe_seen |= on;
    spi_byte(a[23:16], rx, oa, on); oe_seen |= on;
    spi_byte(a[15:8], rx, oa, on); oe_seen |= on;
    spi_byte(a[7:0], rx, oa, on); oe_seen |= on;
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    logic [7:0]  rx;
    logic        oa, on, hdr_oe;
    logic [23:0] ea;
    int          r0, e0;
    r0 = rd_cnt;
    e0 = err_cnt;
    cs_low();
    check("busy_in_frame", busy, 1'b1);
    send_read_hdr(a, hdr_oe);
    check("read_hdr_oe", hdr_oe, 1'b0);
    for (int k = 0; k < n; k++) begin
      ea = a + 24'(k);
      spi_byte(8'h00, rx, oa, on);
      check("read_data", rx, mem_val(ea));
      check("read_oe", oa, 1'b1);
    end
    cs_high();
    check("read_busy_end", busy, 1'b0);
    check("read_oe_end", spi_miso_oe, 1'b0);
    // One read per byte plus the prefetch issued at the last byte's bit 7.
    check("read_count", rd_cnt - r0, n + 1);
    for (int k = 0; k < n; k++) begin
      ea = a + 24'(k);
      check("read_addr", rd_log[(r0 + k) % 4096], ea);
    end
    check("read_no_err", err_cnt - e0, 0);
  endtask

  task automatic do_rdid(input int n);
    logic [7:0] rx, exp;
    logic       oa, on;
    int         r0;
    r0 = rd_cnt;
    cs_low();
    spi_byte(8'h9F, rx, oa, on);
    check("rdid_cmd_oe", on, 1'b0);
    for (int k = 0; k < n; k++) begin
      exp = (k == 0) ? JID[23:16] : (k == 1) ? JID[15:8] : (k == 2) ? JID[7:0] : 8'h00;
      spi_byte(8'h00, rx, oa, on);
      check("rdid_data", rx, exp);
      check("rdid_oe", oa, 1'b1);
    end
    cs_high();
    check("rdid_no_rd", rd_cnt - r0, 0);
  endtask

  task automatic do_rdsr(input int n);
    logic [7:0] rx;
    logic       oa, on;
    cs_low();
    spi_byte(8'h05, rx, oa, on);
    for (int k = 0; k < n; k++) begin
      spi_byte(8'h00, rx, oa, on);
      check("rdsr_data", rx, 8'h00);
      check("rdsr_oe", oa, 1'b1);
    end
    cs_high();
  endtask

  task automatic do_badop(input logic [7:0] op);
    logic [7:0] rx;
    logic       oa, on;
    int         e0, o0, r0;
    e0 = err_cnt;
    o0 = oe_cyc;
    r0 = rd_cnt;
    cs_low();
    spi_byte(op, rx, oa, on);
    clks(2);
    check("badop_err_pulse", err_cnt - e0, 1);
    spi_byte($urandom, rx, oa, on);
    spi_byte($urandom, rx, oa, on);
    check("badop_miso", rx, 8'h00);
    cs_high();
    check("badop_err_once", err_cnt - e0, 1);
    check("badop_oe_cycles", oe_cyc - o0, 0);
    check("badop_no_rd", rd_cnt - r0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, spi_miso, 1'b0);
    check({tag, "_oe"}, spi_miso_oe, 1'b0);
    check({tag, "_mem_rd"}, mem_rd, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 24'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_cmd_err"}, cmd_err, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rx, op;
    logic        r, o, oa, on, hdr_oe;
    int          r0, e0, o0;
    logic [23:0] a;

    rst_n = 1'b0;
    clks(6);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    clks(6);

    // Directed cases
    do_read(24'h000100, 2);
    do_rdid(5);
    do_badop(8'hAB);
    do_rdsr(2);
    do_read(24'hFFFFFF, 3);

    // CS abort after 12 address bits
    r0 = rd_cnt;
    cs_low();
    spi_byte(8'h03, rx, oa, on);
    for (int i = 0; i < 12; i++) spi_bit(1'b1, r, o);
    cs_high();
    check("abort_busy", busy, 1'b0);
    check("abort_no_rd", rd_cnt - r0, 0);
    do_read(24'h000100, 1);

    // Reset in the middle of a data phase
    cs_low();
    send_read_hdr(24'h000100, hdr_oe);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, r, o);
    rst_n = 1'b0;
    clks(3);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    r0 = rd_cnt;
    e0 = err_cnt;
    o0 = oe_cyc;
    for (int i = 0; i < 4; i++) spi_bit(1'b0, r, o);
    spi_byte(8'h03, rx, oa, on);
    spi_byte(8'h9F, rx, oa, on);
    spi_byte(8'h00, rx, oa, on);
    spi_byte(8'h00, rx, oa, on);
    cs_high();
    check("midrst_no_rd", rd_cnt - r0, 0);
    check("midrst_no_err", err_cnt - e0, 0);
    check("midrst_no_oe", oe_cyc - o0, 0);
    do_read(24'h000100, 2);

    // Randomized mix
    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = 24'($urandom);
          if ($urandom_range(0, 3) == 0) a = 24'hFFFFFF - 24'($urandom_range(0, 2));
          do_read(a, $urandom_range(1, 4));
        end
        1: do_rdid($urandom_range(1, 5));
        2: do_rdsr($urandom_range(1, 3));
        default: begin
          do op = 8'($urandom);
          while (op == 8'h03 || op == 8'h9F || op == 8'h05);
          do_badop(op);
        end
      endcase
    end

    check("mem_rd_back_to_back", b2b_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

Synthesizable SPI mode-0 flash responder: the target side of the SoC SPI flash interface. It decodes READ (0x03), RDID (0x9F) and RDSR (0x05) from an SPI initiator and serves data from a byte-wide synchronous memory port. It oversamples the SPI pins on the system clock, so it can stand in for the external flash model in FPGA prototypes and in lightweight benches.

## Interface
Parameters:
- `ADDR_W`, 24: flash byte-address width; the address counter wraps at 2^ADDR_W.
- `JEDEC_ID`, 24'h20BA18: 3-byte ID returned by RDID, MSB first.
- `SYNC_STAGES`, 2: synchronizer depth on `spi_clk`, `spi_cs_n` and `spi_mosi`.

Ports:
- One clock; reset is synchronous and active-low. These are the `clk` and `rst_n` ports below.
- `clk`  in  1  system clock; `spi_clk` frequency must not exceed `clk`/4.
- `rst_n`  in  1  synchronous active-low reset.
- `spi_clk`  in  1  SPI serial clock from the initiator (CPOL=0, CPHA=0).
- `spi_cs_n`  in  1  chip select, active low.
- `spi_mosi`  in  1  serial data in.
- `spi_miso`  out  1  serial data out.
- `spi_miso_oe`  out  1  MISO output enable; high only in response phases.
- `mem_rd`  out  1  one-cycle memory read strobe.
- `mem_addr`  out  ADDR_W  memory byte address, valid while `mem_rd` is high.
- `mem_rdata`  in  8  read data, valid exactly 1 `clk` after `mem_rd`.
- `busy`  out  1  high while chip select is active (synchronized).
- `cmd_err`  out  1  one-cycle pulse when an unsupported opcode completes.

## Operation
- Inputs pass through `SYNC_STAGES` flops. Edge detection on synchronized `spi_clk` produces `rise` and `fall` strobes.
- A bit counter counts 0–7 on each `rise`. MOSI is shifted MSB first on `rise`.
- MISO shift register: output byte loaded at a byte boundary, and the next bit is presented on each `fall`.
- States:
  - **IDLE**: waits for CS low.
  - **CMD**: after 8 bits, decodes the opcode. 0x03 goes to **ADDR**. 0x9F goes to **ID** with byte index 0. 0x05 goes to **STAT**. Any other value pulses `cmd_err` and goes to **IGNORE**.
  - **ADDR**: 24 bits MSB first, then **DATA**. Bits above `ADDR_W` are discarded.
  - **DATA**: on the `rise` that completes the address, issue `mem_rd` with that address. Load `mem_rdata` the next cycle. On each subsequent 8th data-bit `rise`, the address increments (mod 2^ADDR_W) and `mem_rd` is issued again. Streams until CS goes high.
  - **ID**: returns `JEDEC_ID[23:16]`, `[15:8]`, `[7:0]`, then 0x00 repeated.
  - **STAT**: returns 0x00 repeated (never busy, no write-enable latch).
  - **IGNORE**: MISO 0 and `spi_miso_oe` 0 until CS goes high.
- Synchronized CS high in any state returns to IDLE, clears the counters and drops `spi_miso_oe` in the same cycle. A partial byte is discarded.
- Reset values: `spi_miso`=0, `spi_miso_oe`=0, `mem_rd`=0, `mem_addr`=0, `busy`=0, `cmd_err`=0, state=IDLE.
- Reset takes precedence over all SPI activity. `rst_n` low mid-transfer aborts it, and the responder ignores the rest of that CS-low frame: it waits for CS high before accepting a new command.

## Timing
- Input-to-internal latency is `SYNC_STAGES` `clk` cycles, plus 1 cycle for edge detection.
- For the first byte of a response phase, MSB drive:
  - The first byte is loaded ≤2 `clk` after the final command/address `rise`.
  - Its MSB is driven on `spi_miso` at the immediately following `fall`, which comes ≥2 `clk` later given the `clk`/4 limit.
  - The initiator therefore samples it on the next `rise`.
- For the next byte in a stream:
  - `mem_rd` for it is issued in the cycle after the `rise` of bit 7 of the current byte.
  - The data is loaded 1 cycle later and shifted out from the next `fall`.
- `spi_miso_oe` rises together with the first driven response bit.
- `cmd_err` is high for exactly 1 cycle, 1 cycle after the 8th opcode `rise`.
- `mem_rd` is never high on two consecutive cycles.

## Structure
- Package `spi_flash_pkg` holds:
  - Opcode constants `OP_READ`=8'h03, `OP_RDID`=8'h9F and `OP_RDSR`=8'h05.
  - The state enum (IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE).
  - Default `JEDEC_ID`.
- Sub-module `spi_sync_edge`: parameterized N-stage synchronizer for the three inputs, with `rise`/`fall` strobe generation for `spi_clk`.
- The top level holds the FSM, bit/byte counters, address counter and MISO/MOSI shift registers.

## Test plan
- **READ, two bytes**: memory 0x000100=0xA5 and 0x000101=0x3C; send 0x03 00 01 00, then clock 16 bits → MISO 0xA5, 0x3C; `mem_addr` 0x100 then 0x101.
- **RDID**: send 0x9F, then 32 bits → MISO 0x20, 0xBA, 0x18, 0x00; `mem_rd` never asserted.
- **Unsupported opcode**: send 0xAB → one `cmd_err` pulse, `spi_miso_oe` stays 0. After CS high, RDSR returns 0x00 with `spi_miso_oe`=1.
- **Address wrap**: READ at 0xFFFFFF → `mem_addr` 0xFFFFFF then 0x000000; bytes streamed in that order.
- **CS abort**: CS high after 12 address bits → IDLE, `busy`=0. A following READ at 0x000100 returns 0xA5.
- **Reset mid-transfer**: `rst_n` low during DATA → all outputs at reset values. The rest of the frame is ignored, and the next frame's READ succeeds.
